// File: rtl/dsa_avalon_bridge_if.sv
// Bus bundles for dsa_avalon_bridge.
//   dsa_avs_if  : Avalon-MM side; the bridge connects as slave.
//   dsa_host_if : DSA host port (h_*); the bridge connects as master.

interface dsa_avs_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) ();
    localparam int BE_W = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] avs_address;
    logic                  avs_read;
    logic                  avs_write;
    logic [BE_W-1:0]       avs_byteenable;
    logic [DATA_WIDTH-1:0] avs_writedata;
    logic [DATA_WIDTH-1:0] avs_readdata;
    logic                  avs_readdatavalid;
    logic                  avs_waitrequest;
    logic [1:0]            avs_response;

    modport master (
        output avs_address, avs_read, avs_write, avs_byteenable, avs_writedata,
        input  avs_readdata, avs_readdatavalid, avs_waitrequest, avs_response
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_byteenable, avs_writedata,
        output avs_readdata, avs_readdatavalid, avs_waitrequest, avs_response
    );
endinterface

interface dsa_host_if #(
    parameter int H_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH   = 32
) ();
    logic                    h_wr_en;
    logic                    h_rd_en;
    logic [H_ADDR_WIDTH-1:0] h_addr;
    logic [DATA_WIDTH-1:0]   h_wdata;
    logic [DATA_WIDTH-1:0]   h_rdata;
    logic                    h_rvalid;

    modport master (
        output h_wr_en, h_rd_en, h_addr, h_wdata,
        input  h_rdata, h_rvalid
    );

    modport slave (
        input  h_wr_en, h_rd_en, h_addr, h_wdata,
        output h_rdata, h_rvalid
    );
endinterface

// File: rtl/dsa_avalon_bridge.sv
// dsa_avalon_bridge: Avalon-MM slave in front of the DSA host port.
// One transaction in flight; partial writes become read-modify-write;
// reads complete whenever the host raises h_rvalid.
// Optional read timeout is compiled in with `define DSA_BRIDGE_TIMEOUT_EN.

module dsa_avalon_bridge #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int H_ADDR_WIDTH   = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    dsa_avs_if.slave   avs,
    dsa_host_if.master host
);
    localparam int BE_W = DATA_WIDTH / 8;

    // Elaboration-time guards on the configuration.
    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $error("dsa_avalon_bridge: DATA_WIDTH must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("dsa_avalon_bridge: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD_ISSUE, S_RD_WAIT,
        S_RMW_ISSUE, S_RMW_WAIT, S_RMW_WR, S_RESP
    } state_e;

    state_e                  state_q,   state_d;
    logic [H_ADDR_WIDTH-1:0] h_addr_q,  h_addr_d;
    logic [DATA_WIDTH-1:0]   h_wdata_q, h_wdata_d;
    logic [BE_W-1:0]         be_q,      be_d;
    logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
    logic                    h_wr_en_q, h_wr_en_d;
    logic                    h_rd_en_q, h_rd_en_d;
    logic                    rvalid_q,  rvalid_d;
    logic [DATA_WIDTH-1:0]   merged;

`ifdef DSA_BRIDGE_TIMEOUT_EN
    localparam int                  CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [1:0]       resp_q, resp_d;
    logic             timeout;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state and next-output computation for the whole bridge.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        h_addr_d  = h_addr_q;
        h_wdata_d = h_wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        h_wr_en_d = 1'b0;
        h_rd_en_d = 1'b0;
        rvalid_d  = 1'b0;
`ifdef DSA_BRIDGE_TIMEOUT_EN
        resp_d    = resp_q;
        cnt_d     = cnt_q;
        if (state_q inside {S_RD_ISSUE, S_RD_WAIT, S_RMW_ISSUE, S_RMW_WAIT}) begin
            cnt_d = cnt_q + 1'b1;
        end
`endif

        // Byte-lane merge: enabled lanes from the pending write, the rest from the host word.
        merged = host.h_rdata;
        for (int i = 0; i < BE_W; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = h_wdata_q[8*i +: 8];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (avs.avs_write) begin
                    // A simultaneous read is dropped: the write takes priority.
                    if (avs.avs_byteenable != '0) begin
                        h_addr_d  = H_ADDR_WIDTH'(avs.avs_address);
                        h_wdata_d = avs.avs_writedata;
                        be_d      = avs.avs_byteenable;
`ifdef DSA_BRIDGE_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                        if (&avs.avs_byteenable) begin
                            state_d   = S_WR;
                            h_wr_en_d = 1'b1;
                        end else begin
                            state_d   = S_RMW_ISSUE;
                            h_rd_en_d = 1'b1;
                        end
                    end
                end else if (avs.avs_read) begin
                    h_addr_d  = H_ADDR_WIDTH'(avs.avs_address);
                    state_d   = S_RD_ISSUE;
                    h_rd_en_d = 1'b1;
`ifdef DSA_BRIDGE_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            S_WR:        state_d = S_IDLE;
            S_RD_ISSUE:  state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (host.h_rvalid) begin
                    rdata_d  = host.h_rdata;
                    rvalid_d = 1'b1;
                    state_d  = S_RESP;
`ifdef DSA_BRIDGE_TIMEOUT_EN
                    resp_d   = 2'b00;
                end else if (timeout) begin
                    rdata_d  = TIMEOUT_DATA;
                    resp_d   = 2'b10;
                    rvalid_d = 1'b1;
                    state_d  = S_RESP;
`endif
                end
            end
            S_RMW_ISSUE: state_d = S_RMW_WAIT;
            S_RMW_WAIT: begin
                if (host.h_rvalid) begin
                    h_wdata_d = merged;
                    h_wr_en_d = 1'b1;
                    state_d   = S_RMW_WR;
`ifdef DSA_BRIDGE_TIMEOUT_EN
                end else if (timeout) begin
                    state_d   = S_IDLE;
`endif
                end
            end
            S_RMW_WR:    state_d = S_IDLE;
            S_RESP:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; synchronous reset discards any pending transaction.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q   <= S_IDLE;
            h_addr_q  <= '0;
            h_wdata_q <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            h_wr_en_q <= 1'b0;
            h_rd_en_q <= 1'b0;
            rvalid_q  <= 1'b0;
`ifdef DSA_BRIDGE_TIMEOUT_EN
            cnt_q     <= '0;
            resp_q    <= 2'b00;
`endif
        end else begin
            state_q   <= state_d;
            h_addr_q  <= h_addr_d;
            h_wdata_q <= h_wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            h_wr_en_q <= h_wr_en_d;
            h_rd_en_q <= h_rd_en_d;
            rvalid_q  <= rvalid_d;
`ifdef DSA_BRIDGE_TIMEOUT_EN
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
`endif
        end
    end

    // Requests are only accepted in IDLE outside of reset.
    assign avs.avs_waitrequest   = reset || (state_q != S_IDLE);
    assign avs.avs_readdata      = rdata_q;
    assign avs.avs_readdatavalid = rvalid_q;
`ifdef DSA_BRIDGE_TIMEOUT_EN
    assign avs.avs_response      = resp_q;
`else
    assign avs.avs_response      = 2'b00;
`endif

    assign host.h_wr_en = h_wr_en_q;
    assign host.h_rd_en = h_rd_en_q;
    assign host.h_addr  = h_addr_q;
    assign host.h_wdata = h_wdata_q;

endmodule

// File: tb/tb_dsa_avalon_bridge.sv
// Self-checking bench for dsa_avalon_bridge.
// Expected host accesses and Avalon responses are queued by a transaction
// model (word memory + byte-lane merge); one negedge process checks every
// strobe against those queues. Directed checks pin latencies and reset state.

module tb_dsa_avalon_bridge;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int HAW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dsa_avs_if  #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW))    avs ();
    dsa_host_if #(.H_ADDR_WIDTH(HAW), .DATA_WIDTH(DW)) host ();

    dsa_avalon_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .H_ADDR_WIDTH(HAW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .avs  (avs),
        .host (host)
    );

    typedef struct packed { logic [15:0] a; logic [31:0] d; } wr_t;
    typedef struct packed { logic [31:0] d; logic [1:0] r; } rsp_t;

    wr_t         exp_wr_q[$];
    logic [15:0] exp_rd_q[$];
    rsp_t        exp_rsp_q[$];

    logic [31:0] mem       [int];  // contents of the host device
    logic [31:0] model_mem [int];  // what the model believes the host holds

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0, rd_cnt = 0, rdv_cnt = 0, wreq_cnt = 0;
    int t_wr = 0, t_rd = 0, t_rdv = 0;
    int rd_lat = 1;  // host read latency; 0 = never respond

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [3:0] be, input logic [31:0] wd,
                                          input logic [31:0] old);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] model_rd(input logic [15:0] a);
        return model_mem.exists(int'(a)) ? model_mem[int'(a)] : 32'h0;
    endfunction

    function automatic logic [31:0] dev_rd(input logic [15:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : 32'h0;
    endfunction

    // Host device: answers each h_rd_en after rd_lat cycles with one h_rvalid pulse.
    logic [15:0] resp_addr;
    int          resp_lat;
    initial begin
        host.h_rvalid = 1'b0;
        host.h_rdata  = '0;
        forever begin
            @(negedge clk);
            if (host.h_rd_en && !reset) begin
                resp_lat  = rd_lat;
                resp_addr = host.h_addr;
                if (resp_lat > 0) begin
                    repeat (resp_lat) @(posedge clk);
                    #1;
                    host.h_rvalid = 1'b1;
                    host.h_rdata  = dev_rd(resp_addr);
                    @(posedge clk);
                    #1;
                    host.h_rvalid = 1'b0;
                end
            end
        end
    end

    // Compare process: every strobe must match the head of its expectation queue.
    wr_t  wr_e;
    rsp_t rsp_e;
    logic [15:0] rd_e;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (avs.avs_waitrequest) wreq_cnt++;
                if (host.h_wr_en) begin
                    wr_cnt++;
                    t_wr = cyc;
                    check("h_wr_en_expected", 64'(exp_wr_q.size() != 0), 64'(1));
                    if (exp_wr_q.size() != 0) begin
                        wr_e = exp_wr_q.pop_front();
                        check("h_wr_addr", 64'(host.h_addr), 64'(wr_e.a));
                        check("h_wr_data", 64'(host.h_wdata), 64'(wr_e.d));
                    end
                    mem[int'(host.h_addr)] = host.h_wdata;
                end
                if (host.h_rd_en) begin
                    rd_cnt++;
                    t_rd = cyc;
                    check("h_rd_en_expected", 64'(exp_rd_q.size() != 0), 64'(1));
                    if (exp_rd_q.size() != 0) begin
                        rd_e = exp_rd_q.pop_front();
                        check("h_rd_addr", 64'(host.h_addr), 64'(rd_e));
                    end
                end
                if (avs.avs_readdatavalid) begin
                    rdv_cnt++;
                    t_rdv = cyc;
                    check("readdatavalid_expected", 64'(exp_rsp_q.size() != 0), 64'(1));
                    if (exp_rsp_q.size() != 0) begin
                        rsp_e = exp_rsp_q.pop_front();
                        check("readdata", 64'(avs.avs_readdata), 64'(rsp_e.d));
                        check("response", 64'(avs.avs_response), 64'(rsp_e.r));
                    end
                end
            end
        end
    end

    // Present one request and hold it until accepted (bounded).
    task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] be, output int t_acc);
        int   n;
        logic ok;
        n     = 0;
        ok    = 1'b0;
        t_acc = 0;
        @(posedge clk);
        #1;
        avs.avs_address    = a;
        avs.avs_writedata  = d;
        avs.avs_byteenable = be;
        avs.avs_read       = rd;
        avs.avs_write      = wr;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (!avs.avs_waitrequest && !reset) begin
                ok    = 1'b1;
                t_acc = cyc;
            end
            n++;
            @(posedge clk);
            #1;
        end
        avs.avs_read  = 1'b0;
        avs.avs_write = 1'b0;
        check("request_accepted", 64'(ok), 64'(1));
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be,
                            input logic also_read, output int t_acc);
        logic [31:0] nv;
        if (be == 4'hF) begin
            exp_wr_q.push_back('{a: a, d: d});
            model_mem[int'(a)] = d;
        end else if (be != 4'h0) begin
            nv = merge(be, d, model_rd(a));
            exp_rd_q.push_back(a);
            exp_wr_q.push_back('{a: a, d: nv});
            model_mem[int'(a)] = nv;
        end
        issue(also_read, 1'b1, a, d, be, t_acc);
    endtask

    task automatic do_read(input logic [15:0] a, input int lat, input logic tmo, output int t_acc);
        rd_lat = lat;
        exp_rd_q.push_back(a);
        if (tmo) exp_rsp_q.push_back('{d: 32'hDEAD_BEEF, r: 2'b10});
        else     exp_rsp_q.push_back('{d: model_rd(a), r: 2'b00});
        issue(1'b1, 1'b0, a, 32'h0, 4'h0, t_acc);
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((avs.avs_waitrequest || exp_wr_q.size() != 0 || exp_rd_q.size() != 0 ||
                    exp_rsp_q.size() != 0) && n < 300);
        check({name, "_completed"}, 64'(n < 300), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int ta, w0, r0, v0, q0;

    initial begin
        avs.avs_address    = '0;
        avs.avs_read       = 1'b0;
        avs.avs_write      = 1'b0;
        avs.avs_byteenable = '0;
        avs.avs_writedata  = '0;
        mem[32'h20]        = 32'h1111_2222;  model_mem[32'h20] = 32'h1111_2222;
        mem[32'h04]        = 32'h1234_5678;  model_mem[32'h04] = 32'h1234_5678;
        mem[32'h30]        = 32'h0BAD_F00D;  model_mem[32'h30] = 32'h0BAD_F00D;

        // Model pins: hand-computed lane merges.
        check("model_merge_be3", 64'(merge(4'h3, 32'hFFFF_BEEF, 32'h1111_2222)), 64'h1111_BEEF);
        check("model_merge_beA", 64'(merge(4'hA, 32'hAABB_CCDD, 32'h1122_3344)), 64'hAA22_CC44);

        // Reset state.
        @(negedge clk);
        check("reset_waitrequest", 64'(avs.avs_waitrequest), 64'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_waitrequest", 64'(avs.avs_waitrequest), 64'(0));
        check("reset_outputs", 64'({host.h_wr_en, host.h_rd_en, avs.avs_readdatavalid,
                                    avs.avs_response}), 64'(0));
        check("reset_readdata", 64'(avs.avs_readdata), 64'(0));
        check("reset_h_addr_wdata", 64'({host.h_addr, host.h_wdata}), 64'(0));

        // 1. Full write.
        w0 = wr_cnt;
        do_write(16'h0010, 32'hA5A5_5A5A, 4'hF, 1'b0, ta);
        q0 = wreq_cnt;
        repeat (5) @(negedge clk);
        check("t1_wr_pulses", 64'(wr_cnt - w0), 64'(1));
        check("t1_wr_latency", 64'(t_wr - ta), 64'(1));
        check("t1_waitrequest_cycles", 64'(wreq_cnt - q0), 64'(1));
        wait_quiet("t1");

        // 2. Reads with host latency 1 and 7.
        v0 = rdv_cnt;
        do_read(16'h0004, 1, 1'b0, ta);
        wait_quiet("t2a");
        check("t2a_latency", 64'(t_rdv - ta), 64'(3));
        do_read(16'h0004, 7, 1'b0, ta);
        wait_quiet("t2b");
        check("t2b_latency", 64'(t_rdv - ta), 64'(9));
        check("t2_rdv_pulses", 64'(rdv_cnt - v0), 64'(2));
        repeat (3) @(negedge clk);
        check("t2_readdata_holds", 64'(avs.avs_readdata), 64'h1234_5678);

        // 3. Partial write: read-modify-write.
        w0 = wr_cnt; r0 = rd_cnt;
        rd_lat = 2;
        do_write(16'h0020, 32'hFFFF_BEEF, 4'h3, 1'b0, ta);
        wait_quiet("t3");
        check("t3_rd_pulses", 64'(rd_cnt - r0), 64'(1));
        check("t3_wr_pulses", 64'(wr_cnt - w0), 64'(1));
        check("t3_rd_before_wr", 64'(t_wr > t_rd), 64'(1));
        check("t3_host_word", 64'(dev_rd(16'h0020)), 64'h1111_BEEF);

        // 4a. Zero byte-enable write: accepted, no host access, no backpressure.
        w0 = wr_cnt; r0 = rd_cnt; q0 = wreq_cnt;
        do_write(16'h0024, 32'h5555_5555, 4'h0, 1'b0, ta);
        repeat (4) @(negedge clk);
        check("t4a_no_strobes", 64'((wr_cnt - w0) + (rd_cnt - r0)), 64'(0));
        check("t4a_no_waitrequest", 64'(wreq_cnt - q0), 64'(0));

        // 4b. Read and write together: write wins, read dropped.
        w0 = wr_cnt; r0 = rd_cnt; v0 = rdv_cnt;
        do_write(16'h0050, 32'hCAFE_F00D, 4'hF, 1'b1, ta);
        wait_quiet("t4b");
        repeat (6) @(negedge clk);
        check("t4b_wr_pulses", 64'(wr_cnt - w0), 64'(1));
        check("t4b_no_read", 64'((rd_cnt - r0) + (rdv_cnt - v0)), 64'(0));

        // 5. Reset during RD_WAIT, late h_rvalid must be ignored.
        r0 = rd_cnt; v0 = rdv_cnt;
        do_read(16'h0030, 10, 1'b0, ta);
        for (int i = 0; i < 20 && rd_cnt == r0; i++) @(negedge clk);
        check("t5_read_issued", 64'(rd_cnt - r0), 64'(1));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_rsp_q.delete();
        @(negedge clk);
        check("t5_reset_waitrequest", 64'(avs.avs_waitrequest), 64'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("t5_no_readdatavalid", 64'(rdv_cnt - v0), 64'(0));
        check("t5_idle_after_reset", 64'(avs.avs_waitrequest), 64'(0));
        check("t5_readdata_cleared", 64'(avs.avs_readdata), 64'(0));
        do_read(16'h0030, 2, 1'b0, ta);
        wait_quiet("t5_next");
        check("t5_next_latency", 64'(t_rdv - ta), 64'(4));
        check("t5_next_rdv_pulses", 64'(rdv_cnt - v0), 64'(1));

`ifdef DSA_BRIDGE_TIMEOUT_EN
        // 6. Host never answers: timeout response 16 cycles after h_rd_en.
        v0 = rdv_cnt;
        do_read(16'h0040, 0, 1'b1, ta);
        wait_quiet("t6");
        check("t6_timeout_latency", 64'(t_rdv - t_rd), 64'(16));
        check("t6_rdv_pulses", 64'(rdv_cnt - v0), 64'(1));
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
